// File: rtl/conv_tuser_gen_pkg.sv
// Shared TUSER bit layout, FSM state type and config-beat field layout for the conv input stream.
// The pad filter and column-mask logic read the same I_* indices.
package conv_tuser_pkg;

    localparam int KW2_W  = 2;
    localparam int SW_W   = 1;
    localparam int COLS_W = 10;
    localparam int ROWS_W = 10;
    localparam int CIN_W  = 10;

    localparam int I_IS_CONFIG    = 0;
    localparam int I_IS_CIN_LAST  = 1;
    localparam int I_IS_COLS_1_K2 = 2;
    localparam int I_IS_COL_VALID = 3;
    localparam int I_KW2          = 4;
    localparam int I_SW_1         = I_KW2 + KW2_W;
    localparam int TUSER_WIDTH    = I_SW_1 + SW_W;

    typedef enum logic [0:0] {
        S_CONFIG = 1'b0,
        S_DATA   = 1'b1
    } state_t;

    // Config beat low bits, kw2 at the LSBs
    typedef struct packed {
        logic [ROWS_W-1:0] rows_1;
        logic [CIN_W-1:0]  cin_1;
        logic [COLS_W-1:0] cols_1;
        logic [SW_W-1:0]   sw_1;
        logic [KW2_W-1:0]  kw2;
    } cfg_t;

    localparam int CFG_WIDTH = $bits(cfg_t);

endpackage

// File: rtl/conv_tuser_gen_wrap_counter.sv
// Position counter that wraps to zero after reaching max; last flags the terminal count.
module tuser_wrap_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_r;

    // Count register: clear wins over enable, wrap at max
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_r <= {W{1'b0}};
        end else if (en) begin
            count_r <= (count_r == max) ? {W{1'b0}} : count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign last  = (count_r == max);

endmodule

// File: rtl/conv_tuser_gen.sv
// Per-beat TUSER sideband generator for the conv input stream (config beat + rows*cols*cin data beats).
// Optional macro CONV_TUSER_GEN_TLAST_EN adds the m_last output flagging the final data beat.
module conv_tuser_gen
    import conv_tuser_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BITS_KW2   = KW2_W,
    parameter int BITS_SW    = SW_W,
    parameter int BITS_COLS  = COLS_W,
    parameter int BITS_ROWS  = ROWS_W,
    parameter int BITS_CIN   = CIN_W
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic [TUSER_WIDTH-1:0] m_user,
`ifdef CONV_TUSER_GEN_TLAST_EN
    output logic                   m_last,
`endif
    output logic                   m_valid,
    input  logic                   m_ready
);

    state_t                 state_r;
    logic [BITS_KW2-1:0]    kw2_r;
    logic [BITS_SW-1:0]     sw_1_r;
    logic [BITS_COLS-1:0]   cols_1_r;
    logic [BITS_CIN-1:0]    cin_1_r;
    logic [BITS_ROWS-1:0]   rows_1_r;
    logic [BITS_COLS-1:0]   thresh_r;
    logic                   k2_ok_r;
    logic [DATA_WIDTH-1:0]  m_data_r;
    logic [TUSER_WIDTH-1:0] m_user_r;
    logic                   m_valid_r;

    cfg_t                   cfg_s;
    logic [BITS_COLS:0]     thresh_s;
    logic                   k2_ok_s;
    logic                   fire_s, cfg_fire_s, data_fire_s;
    logic                   col_en_s, row_en_s, ph_clr_s;
    logic [BITS_CIN-1:0]    cin_cnt_unused_s;
    logic [BITS_ROWS-1:0]   row_cnt_unused_s;
    logic [BITS_COLS-1:0]   col_cnt_s;
    logic [BITS_SW-1:0]     ph_cnt_s;
    logic                   cin_last_s, col_last_s, row_last_s, ph_last_unused_s;
    logic                   block_end_s;
    logic [TUSER_WIDTH-1:0] user_s;

    assign cfg_s       = cfg_t'(s_data[CFG_WIDTH-1:0]);
    assign s_ready     = !areset && (!m_valid_r || m_ready);
    assign fire_s      = s_valid && s_ready;
    assign cfg_fire_s  = fire_s && (state_r == S_CONFIG);
    assign data_fire_s = fire_s && (state_r == S_DATA);
    assign col_en_s    = data_fire_s && cin_last_s;
    assign row_en_s    = col_en_s && col_last_s;
    assign ph_clr_s    = cfg_fire_s || row_en_s;
    assign block_end_s = cin_last_s && col_last_s && row_last_s;

    // Negative threshold (kw2 wider than the row) disables the edge flag
    assign thresh_s = {1'b0, cfg_s.cols_1} - {{(BITS_COLS + 1 - BITS_KW2){1'b0}}, cfg_s.kw2};
    assign k2_ok_s  = (cfg_s.kw2 != {BITS_KW2{1'b0}}) && !thresh_s[BITS_COLS];

    tuser_wrap_counter #(.W(BITS_CIN)) u_cin_cnt (
        .clk(aclk), .rst(areset), .clr(cfg_fire_s), .en(data_fire_s),
        .max(cin_1_r), .count(cin_cnt_unused_s), .last(cin_last_s)
    );

    tuser_wrap_counter #(.W(BITS_COLS)) u_col_cnt (
        .clk(aclk), .rst(areset), .clr(cfg_fire_s), .en(col_en_s),
        .max(cols_1_r), .count(col_cnt_s), .last(col_last_s)
    );

    tuser_wrap_counter #(.W(BITS_ROWS)) u_row_cnt (
        .clk(aclk), .rst(areset), .clr(cfg_fire_s), .en(row_en_s),
        .max(rows_1_r), .count(row_cnt_unused_s), .last(row_last_s)
    );

    // Stride phase restarts at every row so column 0 is always valid
    tuser_wrap_counter #(.W(BITS_SW)) u_ph_cnt (
        .clk(aclk), .rst(areset), .clr(ph_clr_s), .en(col_en_s),
        .max(sw_1_r), .count(ph_cnt_s), .last(ph_last_unused_s)
    );

    // Sideband for the beat currently on s_data
    always_comb begin
        user_s = {TUSER_WIDTH{1'b0}};
        if (state_r == S_CONFIG) begin
            user_s[I_IS_CONFIG]           = 1'b1;
            user_s[I_KW2 +: BITS_KW2]     = cfg_s.kw2;
            user_s[I_SW_1 +: BITS_SW]     = cfg_s.sw_1;
        end else begin
            user_s[I_IS_CIN_LAST]         = cin_last_s;
            user_s[I_IS_COLS_1_K2]        = k2_ok_r && (col_cnt_s == thresh_r);
            user_s[I_IS_COL_VALID]        = (ph_cnt_s == {BITS_SW{1'b0}});
            user_s[I_KW2 +: BITS_KW2]     = kw2_r;
            user_s[I_SW_1 +: BITS_SW]     = sw_1_r;
        end
    end

    // FSM, config latch and the single registered output stage
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r   <= S_CONFIG;
            kw2_r     <= {BITS_KW2{1'b0}};
            sw_1_r    <= {BITS_SW{1'b0}};
            cols_1_r  <= {BITS_COLS{1'b0}};
            cin_1_r   <= {BITS_CIN{1'b0}};
            rows_1_r  <= {BITS_ROWS{1'b0}};
            thresh_r  <= {BITS_COLS{1'b0}};
            k2_ok_r   <= 1'b0;
            m_data_r  <= {DATA_WIDTH{1'b0}};
            m_user_r  <= {TUSER_WIDTH{1'b0}};
            m_valid_r <= 1'b0;
`ifdef CONV_TUSER_GEN_TLAST_EN
            m_last    <= 1'b0;
`endif
        end else if (fire_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= s_data;
            m_user_r  <= user_s;
`ifdef CONV_TUSER_GEN_TLAST_EN
            m_last    <= (state_r == S_DATA) && block_end_s;
`endif
            case (state_r)
                S_CONFIG: begin
                    kw2_r    <= cfg_s.kw2;
                    sw_1_r   <= cfg_s.sw_1;
                    cols_1_r <= cfg_s.cols_1;
                    cin_1_r  <= cfg_s.cin_1;
                    rows_1_r <= cfg_s.rows_1;
                    thresh_r <= thresh_s[BITS_COLS-1:0];
                    k2_ok_r  <= k2_ok_s;
                    state_r  <= S_DATA;
                end
                S_DATA: begin
                    state_r <= block_end_s ? S_CONFIG : S_DATA;
                end
                default: begin
                    state_r <= S_CONFIG;
                end
            endcase
        end else if (m_ready) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    assign m_data  = m_data_r;
    assign m_user  = m_user_r;
    assign m_valid = m_valid_r;

endmodule
